// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the unified RAM data port between the CPU load/store
// path and the FPGA keypad/LCD loader.
//
// Ports
//   clk, nrst                    clock, async active-low reset
//   cpu_req/we/addr/wdata        CPU access request (level, held until ack)
//   cpu_rdata, cpu_ack           CPU response (ack is a one-cycle pulse)
//   cpu_enable                   PC advance enable (low while a CPU access waits)
//   cpu_nrst_o                   hold-reset for PC / register file (low in LOAD)
//   fpga_req/we/addr/wdata       FPGA access request, same protocol as CPU
//   fpga_rdata, fpga_ack         FPGA response
//   load_req, load_active        exclusive program-load mode request / status
//   mem_we/addr/wdata, mem_rdata RAM data port (read data one cycle late)
//   conflict_cnt                 contended-arbitration counter
//
// Build option: define MEM_ARB_CONFLICT_CNT_EN to generate the saturating
// conflict counter; otherwise conflict_cnt is tied to zero.
module mem_arbiter #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [31:0]       cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  output logic              cpu_enable,
  output logic              cpu_nrst_o,
  input  logic              fpga_req,
  input  logic              fpga_we,
  input  logic [31:0]       fpga_addr,
  input  logic [DATA_W-1:0] fpga_wdata,
  output logic [DATA_W-1:0] fpga_rdata,
  output logic              fpga_ack,
  input  logic              load_req,
  output logic              load_active,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [15:0]       conflict_cnt
);

  typedef enum logic [2:0] {IDLE, CPU_A, CPU_R, FPGA_A, FPGA_R, LOAD} state_e;

  state_e            state_q, state_d;
  logic              last_gnt_q, last_gnt_d;  // 1: FPGA received the last grant
  logic              arb, cpu_elig, fpga_elig;
  logic              ld_acc;
  logic              cpu_ack_q, fpga_ack_q, ld_ack_q, cpu_nrst_q;
  logic [DATA_W-1:0] cpu_rdata_q, fpga_rdata_q;

  // Upper address bits wrap silently.
  logic unused_addr_hi;
  assign unused_addr_hi = ^{cpu_addr[31:ADDR_W], fpga_addr[31:ADDR_W]};

  assign ld_acc = (state_q == LOAD) && fpga_req;

  // Next-state. In an _R state the side being completed still holds its
  // request (it only drops it once ack is seen), so it is masked out of that
  // arbitration; otherwise it would be granted a second time.
  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    arb        = 1'b0;
    cpu_elig   = 1'b0;
    fpga_elig  = 1'b0;
    case (state_q)
      IDLE:   begin arb = 1'b1; cpu_elig = cpu_req; fpga_elig = fpga_req; end
      CPU_A:  state_d = CPU_R;
      CPU_R:  begin arb = 1'b1; fpga_elig = fpga_req; end
      FPGA_A: state_d = FPGA_R;
      FPGA_R: begin arb = 1'b1; cpu_elig = cpu_req; end
      LOAD:   if (!load_req && !fpga_req) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (arb) begin
      if (load_req) begin
        state_d = LOAD;
      end else if (cpu_elig && fpga_elig) begin
        state_d    = last_gnt_q ? CPU_A : FPGA_A;
        last_gnt_d = !last_gnt_q;
      end else if (cpu_elig) begin
        state_d    = CPU_A;
        last_gnt_d = 1'b0;
      end else if (fpga_elig) begin
        state_d    = FPGA_A;
        last_gnt_d = 1'b1;
      end else begin
        state_d = IDLE;
      end
    end
  end

  // RAM port: driven only in an _A state or by a LOAD-mode FPGA access.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (state_q == CPU_A) begin
      mem_we    = cpu_we;
      mem_addr  = cpu_addr[ADDR_W-1:0];
      mem_wdata = cpu_wdata;
    end else if (state_q == FPGA_A || ld_acc) begin
      mem_we    = fpga_we;
      mem_addr  = fpga_addr[ADDR_W-1:0];
      mem_wdata = fpga_wdata;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q      <= IDLE;
      last_gnt_q   <= 1'b1;
      cpu_ack_q    <= 1'b0;
      fpga_ack_q   <= 1'b0;
      ld_ack_q     <= 1'b0;
      cpu_nrst_q   <= 1'b0;
      cpu_rdata_q  <= '0;
      fpga_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      cpu_ack_q  <= (state_q == CPU_R);
      fpga_ack_q <= (state_q == FPGA_R) || ld_acc;
      ld_ack_q   <= ld_acc;
      cpu_nrst_q <= (state_d != LOAD);
      if (state_q == CPU_R)  cpu_rdata_q  <= mem_rdata;
      if (state_q == FPGA_R) fpga_rdata_q <= mem_rdata;
    end
  end

  // A LOAD-mode ack lands in the cycle the RAM presents the read data, so the
  // data is passed straight through for that cycle.
  assign fpga_rdata  = ld_ack_q ? mem_rdata : fpga_rdata_q;
  assign fpga_ack    = fpga_ack_q;
  assign cpu_rdata   = cpu_rdata_q;
  assign cpu_ack     = cpu_ack_q;
  assign cpu_nrst_o  = cpu_nrst_q;
  assign load_active = (state_q == LOAD);
  assign cpu_enable  = !load_active && !(cpu_req && !cpu_ack_q);

`ifdef MEM_ARB_CONFLICT_CNT_EN
  logic [15:0] cnt_q;
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) cnt_q <= '0;
    else if (arb && cpu_elig && fpga_elig && cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
  end
  assign conflict_cnt = cnt_q;
`else
  assign conflict_cnt = '0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios with literal expectations plus a
// transaction-level model (grant schedule + shadow memory) checked every cycle.
module tb_mem_arbiter;
  localparam int NC = 4096;
`ifdef MEM_ARB_CONFLICT_CNT_EN
  localparam int CNT_EN = 1;
`else
  localparam int CNT_EN = 0;
`endif

  logic        clk = 1'b0;
  logic        nrst;
  logic        cpu_req, cpu_we, fpga_req, fpga_we, load_req;
  logic [31:0] cpu_addr, cpu_wdata, fpga_addr, fpga_wdata;
  logic [31:0] cpu_rdata, fpga_rdata, mem_wdata, mem_rdata;
  logic        cpu_ack, cpu_enable, cpu_nrst_o, fpga_ack, load_active, mem_we;
  logic [11:0] mem_addr;
  logic [15:0] conflict_cnt;

  logic        pre_we;
  logic [11:0] pre_a;
  logic [31:0] pre_d;
  logic [31:0] ram [0:4095];

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(12), .DATA_W(32)) dut (
    .clk(clk), .nrst(nrst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_enable(cpu_enable), .cpu_nrst_o(cpu_nrst_o),
    .fpga_req(fpga_req), .fpga_we(fpga_we), .fpga_addr(fpga_addr), .fpga_wdata(fpga_wdata),
    .fpga_rdata(fpga_rdata), .fpga_ack(fpga_ack),
    .load_req(load_req), .load_active(load_active),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .conflict_cnt(conflict_cnt)
  );

  // Synchronous RAM, read-before-write, with a bench preload port.
  always @(posedge clk) begin
    if (pre_we) ram[pre_a] <= pre_d;
    else if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h @%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- model + per-cycle compare ----------------
  logic [31:0] shadow [0:4095];
  bit          e_cack [NC], e_fack [NC], e_cchk [NC], e_fchk [NC];
  bit          e_drive [NC], e_we [NC], e_load [NC], e_nrst [NC];
  logic [31:0] e_crd [NC], e_frd [NC], e_wd [NC];
  logic [11:0] e_addr [NC];
  int          e_cnt [NC];

  initial begin
    int  cyc, next_arb, mask, cnt, s, c3;
    bit  lg_fpga, nload, ce, fe, swe;
    logic [11:0] sa;
    logic [31:0] swd;
    cyc = 0; next_arb = 1; mask = 0; cnt = 0; lg_fpga = 1'b1;
    forever begin
      @(negedge clk);
      if (pre_we) shadow[pre_a] = pre_d;
      if (cyc < NC - 4) begin
        if (!nrst) begin
          chk("rst_cpu_ack", cpu_ack, 0);
          chk("rst_fpga_ack", fpga_ack, 0);
          chk("rst_mem_we", mem_we, 0);
          chk("rst_load_active", load_active, 0);
          chk("rst_cpu_nrst_o", cpu_nrst_o, 0);
          chk("rst_cpu_rdata", cpu_rdata, 0);
          chk("rst_fpga_rdata", fpga_rdata, 0);
          chk("rst_conflict_cnt", conflict_cnt, 0);
          next_arb = cyc + 2; mask = 0; cnt = 0; lg_fpga = 1'b1;
          for (int k = 1; k <= 3; k++) begin
            e_cack[cyc+k] = 0; e_fack[cyc+k] = 0; e_cchk[cyc+k] = 0; e_fchk[cyc+k] = 0;
            e_drive[cyc+k] = 0; e_we[cyc+k] = 0; e_load[cyc+k] = 0; e_nrst[cyc+k] = 0;
            e_cnt[cyc+k] = 0;
          end
        end else begin
          // outputs of this cycle
          chk("cpu_ack", cpu_ack, e_cack[cyc]);
          if (e_cack[cyc] && e_cchk[cyc]) chk("cpu_rdata", cpu_rdata, e_crd[cyc]);
          chk("fpga_ack", fpga_ack, e_fack[cyc]);
          if (e_fack[cyc] && e_fchk[cyc]) chk("fpga_rdata", fpga_rdata, e_frd[cyc]);
          chk("load_active", load_active, e_load[cyc]);
          chk("cpu_nrst_o", cpu_nrst_o, e_nrst[cyc]);
          chk("cpu_enable", cpu_enable, !e_load[cyc] && !(cpu_req && !e_cack[cyc]));
          chk("conflict_cnt", conflict_cnt, (CNT_EN != 0) ? e_cnt[cyc] : 0);
          if (e_load[cyc] && fpga_req) begin
            chk("ld_mem_we", mem_we, fpga_we);
            chk("ld_mem_addr", mem_addr, fpga_addr[11:0]);
            if (fpga_we) chk("ld_mem_wdata", mem_wdata, fpga_wdata);
          end else if (e_drive[cyc]) begin
            chk("mem_we", mem_we, e_we[cyc]);
            chk("mem_addr", mem_addr, e_addr[cyc]);
            if (e_we[cyc]) chk("mem_wdata", mem_wdata, e_wd[cyc]);
          end else begin
            chk("mem_we_idle", mem_we, 0);
          end
          // what the coming edge does
          nload = 1'b0;
          if (e_load[cyc]) begin
            if (fpga_req) begin
              e_fack[cyc+1] = 1; e_fchk[cyc+1] = !fpga_we;
              e_frd[cyc+1] = shadow[fpga_addr[11:0]];
              if (fpga_we) shadow[fpga_addr[11:0]] = fpga_wdata;
            end
            nload = load_req || fpga_req;
            if (!nload) begin next_arb = cyc + 2; mask = 0; end
          end else if (cyc + 1 == next_arb) begin
            ce = cpu_req && (mask != 1);
            fe = fpga_req && (mask != 2);
            if (ce && fe && cnt < 65535) cnt++;
            if (load_req) begin
              nload = 1'b1;
            end else begin
              s = (ce && fe) ? (lg_fpga ? 1 : 2) : ce ? 1 : fe ? 2 : 0;
              if (s == 0) begin
                next_arb = cyc + 2; mask = 0;
              end else begin
                lg_fpga = (s == 2);
                sa  = (s == 1) ? cpu_addr[11:0] : fpga_addr[11:0];
                swe = (s == 1) ? cpu_we : fpga_we;
                swd = (s == 1) ? cpu_wdata : fpga_wdata;
                c3 = cyc + 3;
                e_drive[cyc+1] = 1; e_we[cyc+1] = swe; e_addr[cyc+1] = sa; e_wd[cyc+1] = swd;
                if (s == 1) begin e_cack[c3] = 1; e_cchk[c3] = !swe; e_crd[c3] = shadow[sa]; end
                else        begin e_fack[c3] = 1; e_fchk[c3] = !swe; e_frd[c3] = shadow[sa]; end
                if (swe) shadow[sa] = swd;
                next_arb = c3; mask = s;
              end
            end
          end
          e_load[cyc+1] = nload;
          e_nrst[cyc+1] = !nload;
          e_cnt[cyc+1]  = cnt;
        end
      end
      cyc++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic preload(input logic [11:0] a, input logic [31:0] d);
    pre_we = 1'b1; pre_a = a; pre_d = d;
    step();
    pre_we = 1'b0;
  endtask

  task automatic do_traffic(input int nc, input int nf,
                            input logic cwe, input logic [31:0] ca, input logic [31:0] cwd,
                            input logic fwe, input logic [31:0] fa, input logic [31:0] fwd,
                            output int first_c, output int first_f);
    int cc, fc, t;
    cc = 0; fc = 0; t = 0; first_c = -1; first_f = -1;
    cpu_we = cwe; cpu_addr = ca; cpu_wdata = cwd;
    fpga_we = fwe; fpga_addr = fa; fpga_wdata = fwd;
    cpu_req = (nc > 0); fpga_req = (nf > 0);
    while ((cc < nc || fc < nf) && t < 100) begin
      step(); t++;
      if (cpu_ack) begin cc++; if (first_c < 0) first_c = t; cpu_req = 1'b0; end
      else cpu_req = (cc < nc);
      if (fpga_ack) begin fc++; if (first_f < 0) first_f = t; fpga_req = 1'b0; end
      else fpga_req = (fc < nf);
    end
    cpu_req = 1'b0; fpga_req = 1'b0;
    chk("traffic_done", (cc == nc) && (fc == nf), 1);
  endtask

  initial begin
    int fc_, ff_, acks;
    nrst = 1'b0; pre_we = 1'b0; pre_a = '0; pre_d = '0;
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    fpga_req = 0; fpga_we = 0; fpga_addr = 0; fpga_wdata = 0; load_req = 0;
    step();
    preload(12'd1, 32'h1111_1111);
    preload(12'd5, 32'hDEAD_BEEF);
    preload(12'd7, 32'h0000_0077);
    chk("reset_cpu_nrst_o", cpu_nrst_o, 0);
    chk("reset_load_active", load_active, 0);
    nrst = 1'b1;
    #1 chk("nrst_release_still_low", cpu_nrst_o, 0);
    step();
    chk("nrst_first_edge_high", cpu_nrst_o, 1);
    step();

    // Simultaneous: CPU reads addr 1, FPGA writes 0x1234 to addr 2, twice each.
    do_traffic(2, 2, 1'b0, 32'd1, 32'd0, 1'b1, 32'd2, 32'h1234, fc_, ff_);
    chk("sim_first_grant_cpu", fc_ < ff_, 1);
    chk("sim_conflict_cnt", conflict_cnt, CNT_EN ? 1 : 0);
    step(); step();
    chk("sim_ram2", ram[2], 32'h1234);

    // CPU read alone.
    cpu_we = 1'b0; cpu_addr = 32'd5; cpu_req = 1'b1;
    step();
    chk("rd_en_c0", cpu_enable, 0); chk("rd_ack_c0", cpu_ack, 0); chk("rd_addr_c0", mem_addr, 12'd5);
    step();
    chk("rd_en_c1", cpu_enable, 0); chk("rd_ack_c1", cpu_ack, 0);
    step();
    chk("rd_ack_c2", cpu_ack, 1); chk("rd_data_c2", cpu_rdata, 32'hDEAD_BEEF);
    chk("rd_en_c2", cpu_enable, 1);
    cpu_req = 1'b0;
    step(); step();

    // Address wrap on a CPU write.
    cpu_we = 1'b1; cpu_addr = 32'h0000_1005; cpu_wdata = 32'hCAFE_F00D; cpu_req = 1'b1;
    step();
    chk("wrap_mem_addr", mem_addr, 12'h005); chk("wrap_mem_we", mem_we, 1);
    step(); step();
    chk("wrap_ack", cpu_ack, 1);
    cpu_req = 1'b0; cpu_we = 1'b0;
    step(); step();
    chk("wrap_ram5", ram[5], 32'hCAFE_F00D);

    // Load mode: 4 writes, one read-back, CPU request ignored.
    load_req = 1'b1;
    step();
    chk("ld_active", load_active, 1); chk("ld_cpu_nrst_o", cpu_nrst_o, 0);
    acks = 0;
    for (int i = 0; i < 4; i++) begin
      fpga_req = 1'b1; fpga_we = 1'b1; fpga_addr = i; fpga_wdata = 32'hA0 + i;
      cpu_req = (i == 0);
      step();
      if (fpga_ack) acks++;
    end
    chk("ld_cpu_ack_ignored", cpu_ack, 0);
    fpga_we = 1'b0; fpga_addr = 32'd1; cpu_req = 1'b0;
    step();
    if (fpga_ack) acks++;
    chk("ld_read_data", fpga_rdata, 32'hA1);
    chk("ld_acks", acks, 5);
    fpga_req = 1'b0; load_req = 1'b0;
    chk("ld_nrst_before_exit", cpu_nrst_o, 0);
    step();
    chk("ld_nrst_after_exit", cpu_nrst_o, 1); chk("ld_inactive", load_active, 0);
    for (int i = 0; i < 4; i++) chk("ld_ram", ram[i], 32'hA0 + i);
    step();

    // load_req rises while a CPU access is in its address phase.
    cpu_we = 1'b0; cpu_addr = 32'd5; cpu_req = 1'b1;
    step();
    load_req = 1'b1;
    step();
    chk("lda_active_r", load_active, 0); chk("lda_ack_r", cpu_ack, 0);
    step();
    chk("lda_ack", cpu_ack, 1); chk("lda_data", cpu_rdata, 32'hCAFE_F00D);
    chk("lda_active", load_active, 1);
    cpu_req = 1'b0;
    step();
    load_req = 1'b0;
    step();
    chk("lda_exit", load_active, 0); chk("lda_nrst", cpu_nrst_o, 1);
    step();

    // Second contention after a CPU grant: FPGA must win this time.
    do_traffic(1, 1, 1'b0, 32'd5, 32'd0, 1'b1, 32'd9, 32'h99, fc_, ff_);
    chk("rr_first_grant_fpga", ff_ < fc_, 1);
    chk("rr_conflict_cnt", conflict_cnt, CNT_EN ? 2 : 0);
    step();

    // Reset in the middle of an FPGA write.
    fpga_req = 1'b1; fpga_we = 1'b1; fpga_addr = 32'h100; fpga_wdata = 32'hBAD;
    step();
    chk("mid_mem_we", mem_we, 1); chk("mid_mem_addr", mem_addr, 12'h100);
    #1 nrst = 1'b0;
    #1;
    chk("mid_rst_mem_we", mem_we, 0); chk("mid_rst_fpga_ack", fpga_ack, 0);
    chk("mid_rst_nrst_o", cpu_nrst_o, 0); chk("mid_rst_cnt", conflict_cnt, 0);
    chk("mid_rst_cpu_rdata", cpu_rdata, 0);
    fpga_req = 1'b0; fpga_we = 1'b0;
    step(); step();
    nrst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("mid_no_ack", fpga_ack, 0);
    end
    step(); step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
